psr_access_sequencer: RTL and testbench
=======================================

// Module: psr_access_sequencer
// PURPOSE
//  Sole writer of the Processor Status Register (5-bit {displacement, V,C,Z,N}).
//  Arbitrates PSR write requests from ALU flag updates, explicit software writes,
//  trap entry and trap return (rett), driving the PSR rw/data inputs. Keeps a
//  SAVE_DEPTH-entry shadow stack of PSR values so nested traps restore correctly.
// PARAMETERS
//  FLAG_W      4   width of condition flags (V,C,Z,N)
//  STATUS_W    5   PSR width = FLAG_W+1 (MSB = displacement)
//  SAVE_DEPTH  4   shadow stack entries; DEPTH_W = $clog2(SAVE_DEPTH+1)
// PORTS
//  clk          in   1         clock, all state updates on rising edge
//  reset        in   1         synchronous, active-low; reset==0 clears all state
//  alu_req      in   1         ALU requests flag write; held until alu_gnt
//  alu_flags    in   FLAG_W    flags to write
//  alu_disp     in   1         displacement bit to write with ALU flags
//  alu_gnt      out  1         ALU write accepted this cycle
//  sw_req       in   1         software PSR write request; held until sw_gnt
//  sw_data      in   STATUS_W  full PSR value to write
//  sw_gnt       out  1         software write accepted this cycle
//  trap_req     in   1         trap entry request; held until trap_ack
//  trap_ack     out  1         1-cycle pulse: trap PSR write done
//  rett_req     in   1         trap return request; held until rett_ack
//  rett_ack     out  1         1-cycle pulse: PSR restored (or underflow)
//  psr_status   in   STATUS_W  current PSR content
//  psr_rw       out  1         PSR write enable
//  psr_wdata    out  STATUS_W  {displacement, flags} to PSR
//  depth        out  DEPTH_W   shadow stack occupancy
//  ovf_err      out  1         sticky: trap taken with stack full
//  unf_err      out  1         sticky: rett with stack empty
// BEHAVIOUR
//  - States: IDLE, TRAP_SAVE, TRAP_WRITE, RETT_POP, RETT_WRITE. Reset -> IDLE,
//    depth=0, ovf_err=unf_err=0; while reset==0 all gnt/ack/psr_rw forced 0,
//    psr_wdata=0.
//  - IDLE priority: trap_req > rett_req > sw_req > alu_req. One winner per cycle.
//  - sw/alu win (IDLE only): gnt and psr_rw asserted combinationally same cycle;
//    psr_wdata = sw_data or {alu_disp,alu_flags}; PSR updates next edge. Stay IDLE.
//    Back-to-back grants on consecutive cycles allowed.
//  - trap_req in IDLE -> TRAP_SAVE (no write this cycle).
//  - TRAP_SAVE: if depth<SAVE_DEPTH push psr_status, depth+1; else set ovf_err,
//    no push, depth unchanged. -> TRAP_WRITE.
//  - TRAP_WRITE: psr_rw=1, psr_wdata={1'b0, psr_status[FLAG_W-1:0]},
//    trap_ack=1. -> IDLE. Trap latency: ack 2 cycles after request seen in IDLE.
//  - rett_req in IDLE (no trap_req) -> RETT_POP.
//  - RETT_POP: if depth>0 latch top entry, depth-1 -> RETT_WRITE; else set
//    unf_err, rett_ack=1, psr_rw=0 -> IDLE.
//  - RETT_WRITE: psr_rw=1, psr_wdata=latched entry, rett_ack=1. -> IDLE.
//  - Non-IDLE states: alu_gnt=sw_gnt=0; pending requests wait (no loss).
//  - Requests arriving mid-sequence are sampled only on return to IDLE.
//  - Errors are sticky until reset. Stack is LIFO; no wrap-around.
//  - Reset asserted mid-sequence: next cycle IDLE, stack emptied, no ack issued.
//  - psr_rw asserted at most one cycle per accepted request.
// TESTING
//  1 alu_req=1,alu_flags=4'b0101,alu_disp=1 in IDLE -> same cycle alu_gnt=1,
//    psr_rw=1, psr_wdata=5'b10101; PSR=5'b10101 next cycle.
//  2 sw_req and alu_req same cycle -> sw_gnt first, alu_gnt next cycle; two
//    PSR writes, final value = ALU data.
//  3 PSR=5'b11010, trap_req -> 2 cycles later trap_ack, PSR=5'b01010, depth=1;
//    then rett_req -> rett_ack, PSR=5'b11010, depth=0.
//  4 5 nested traps (SAVE_DEPTH=4) -> depth stays 4, ovf_err=1 after 5th;
//    4 retts restore PSR values in reverse order.
//  5 rett_req with depth=0 -> rett_ack in RETT_POP, no psr_rw, unf_err=1.
//  6 reset=0 during TRAP_SAVE with alu_req high -> no ack, depth=0, outputs 0;
//    after reset=1, alu_gnt in first IDLE cycle.

Source files
------------

// File: rtl/psr_access_sequencer.sv
// ============================================================================
// Module   : psr_access_sequencer
// Purpose  : Sole PSR writer; arbitrates ALU/software/trap/rett updates and
//            keeps a shadow stack of PSR values for nested traps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psr_access_sequencer #(
    parameter int FLAG_W     = 4,
    parameter int STATUS_W   = FLAG_W + 1,
    parameter int SAVE_DEPTH = 4,
    parameter int DEPTH_W    = $clog2(SAVE_DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                alu_req_i,
    input  logic [FLAG_W-1:0]   alu_flags_i,
    input  logic                alu_disp_i,
    output logic                alu_gnt_o,
    input  logic                sw_req_i,
    input  logic [STATUS_W-1:0] sw_data_i,
    output logic                sw_gnt_o,
    input  logic                trap_req_i,
    output logic                trap_ack_o,
    input  logic                rett_req_i,
    output logic                rett_ack_o,
    input  logic [STATUS_W-1:0] psr_status_i,
    output logic                psr_rw_o,
    output logic [STATUS_W-1:0] psr_wdata_o,
    output logic [DEPTH_W-1:0]  depth_o,
    output logic                ovf_err_o,
    output logic                unf_err_o
);

    localparam int                 IDX_W      = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(SAVE_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TRAP_SAVE  = 3'd1,
        ST_TRAP_WRITE = 3'd2,
        ST_RETT_POP   = 3'd3,
        ST_RETT_WRITE = 3'd4
    } state_e;

    state_e              state_q;
    logic [DEPTH_W-1:0]  depth_q;
    logic                ovf_q;
    logic                unf_q;
    logic [STATUS_W-1:0] restore_q;
    logic [STATUS_W-1:0] stack_q [SAVE_DEPTH];

    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    pop_idx;

    assign push_idx = IDX_W'(depth_q);
    assign pop_idx  = IDX_W'(depth_q - DEPTH_ONE);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            depth_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            restore_q <= '0;
            for (int i = 0; i < SAVE_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // sw/alu grants never leave IDLE, so only trap/rett move the FSM
                    if (trap_req_i) begin
                        state_q <= ST_TRAP_SAVE;
                    end else if (rett_req_i) begin
                        state_q <= ST_RETT_POP;
                    end
                end
                ST_TRAP_SAVE: begin
                    if (depth_q < DEPTH_FULL) begin
                        stack_q[push_idx] <= psr_status_i;
                        depth_q           <= depth_q + DEPTH_ONE;
                    end else begin
                        ovf_q <= 1'b1;
                    end
                    state_q <= ST_TRAP_WRITE;
                end
                ST_TRAP_WRITE: begin
                    state_q <= ST_IDLE;
                end
                ST_RETT_POP: begin
                    if (depth_q != '0) begin
                        restore_q <= stack_q[pop_idx];
                        depth_q   <= depth_q - DEPTH_ONE;
                        state_q   <= ST_RETT_WRITE;
                    end else begin
                        unf_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RETT_WRITE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        alu_gnt_o   = 1'b0;
        sw_gnt_o    = 1'b0;
        trap_ack_o  = 1'b0;
        rett_ack_o  = 1'b0;
        psr_rw_o    = 1'b0;
        psr_wdata_o = '0;
        if (reset_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!trap_req_i && !rett_req_i) begin
                        if (sw_req_i) begin
                            sw_gnt_o    = 1'b1;
                            psr_rw_o    = 1'b1;
                            psr_wdata_o = sw_data_i;
                        end else if (alu_req_i) begin
                            alu_gnt_o   = 1'b1;
                            psr_rw_o    = 1'b1;
                            psr_wdata_o = {alu_disp_i, alu_flags_i};
                        end
                    end
                end
                ST_TRAP_WRITE: begin
                    // Trap entry keeps the flags but clears the displacement bit
                    trap_ack_o  = 1'b1;
                    psr_rw_o    = 1'b1;
                    psr_wdata_o = {1'b0, psr_status_i[FLAG_W-1:0]};
                end
                ST_RETT_POP: begin
                    rett_ack_o = (depth_q == '0);
                end
                ST_RETT_WRITE: begin
                    rett_ack_o  = 1'b1;
                    psr_rw_o    = 1'b1;
                    psr_wdata_o = restore_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign depth_o   = depth_q;
    assign ovf_err_o = ovf_q;
    assign unf_err_o = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_psr_access_sequencer.sv
// ============================================================================
// Module   : tb_psr_access_sequencer
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random transactions against a transaction-level PSR/stack model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psr_access_sequencer;

    localparam int SAVE_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_req, alu_disp, alu_gnt;
    logic [3:0] alu_flags;
    logic       sw_req, sw_gnt;
    logic [4:0] sw_data;
    logic       trap_req, trap_ack, rett_req, rett_ack;
    logic       psr_rw;
    logic [4:0] psr_wdata;
    logic [2:0] depth;
    logic       ovf_err, unf_err;

    logic [4:0] psr    = 5'd0;
    int         wr_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] m_psr = 5'd0;
    logic [4:0] m_stack[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    typedef struct {
        logic       rst_n;
        logic       trap;
        logic       rett;
        logic       sw;
        logic       alu;
        logic [4:0] sw_data;
        logic [3:0] flags;
        logic       disp;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    psr_access_sequencer #(
        .FLAG_W    (4),
        .STATUS_W  (5),
        .SAVE_DEPTH(SAVE_DEPTH),
        .DEPTH_W   (3)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .alu_req_i   (alu_req),
        .alu_flags_i (alu_flags),
        .alu_disp_i  (alu_disp),
        .alu_gnt_o   (alu_gnt),
        .sw_req_i    (sw_req),
        .sw_data_i   (sw_data),
        .sw_gnt_o    (sw_gnt),
        .trap_req_i  (trap_req),
        .trap_ack_o  (trap_ack),
        .rett_req_i  (rett_req),
        .rett_ack_o  (rett_ack),
        .psr_status_i(psr),
        .psr_rw_o    (psr_rw),
        .psr_wdata_o (psr_wdata),
        .depth_o     (depth),
        .ovf_err_o   (ovf_err),
        .unf_err_o   (unf_err)
    );

    // The PSR itself lives in the bench and takes whatever the DUT writes.
    always @(posedge clk) begin
        if (psr_rw) begin
            psr    <= psr_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Event record: {cycle[7:0], kind[3:0] (1=trap 2=rett 3=sw 4=alu), psr_rw, wdata[4:0]}
    task automatic serve(input bit t, input bit r, input bit s, input bit a,
                         input logic [4:0] sd, input logic [3:0] af, input logic ad);
        logic [17:0] exp_q[$];
        logic [17:0] got;
        logic [4:0]  popv;
        int          cur;
        int          wr0;
        int          n_wr;
        bit          drop_s, drop_a;
        cur  = 0;
        n_wr = 0;
        if (t) begin
            exp_q.push_back({8'(cur + 2), 4'd1, 1'b1, 1'b0, m_psr[3:0]});
            cur += 3;
            n_wr++;
            if (m_stack.size() < SAVE_DEPTH) m_stack.push_back(m_psr);
            else m_ovf = 1'b1;
            m_psr = {1'b0, m_psr[3:0]};
        end
        if (r) begin
            if (m_stack.size() > 0) begin
                popv = m_stack.pop_back();
                exp_q.push_back({8'(cur + 2), 4'd2, 1'b1, popv});
                cur += 3;
                n_wr++;
                m_psr = popv;
            end else begin
                exp_q.push_back({8'(cur + 1), 4'd2, 1'b0, 5'd0});
                cur += 2;
                m_unf = 1'b1;
            end
        end
        if (s) begin
            exp_q.push_back({8'(cur), 4'd3, 1'b1, sd});
            cur += 1;
            n_wr++;
            m_psr = sd;
        end
        if (a) begin
            exp_q.push_back({8'(cur), 4'd4, 1'b1, ad, af});
            n_wr++;
            m_psr = {ad, af};
        end

        @(negedge clk);
        sw_data   = sd;
        alu_flags = af;
        alu_disp  = ad;
        trap_req  = t;
        rett_req  = r;
        sw_req    = s;
        alu_req   = a;
        wr0       = wr_cnt;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (!(trap_req || rett_req || sw_req || alu_req)) break;
            #1;
            drop_s = sw_gnt;
            drop_a = alu_gnt;
            if (alu_gnt || sw_gnt || trap_ack || rett_ack) begin
                got = {8'(cyc),
                       (trap_ack ? 4'd1 : rett_ack ? 4'd2 : sw_gnt ? 4'd3 : 4'd4),
                       psr_rw, (psr_rw ? psr_wdata : 5'd0)};
                if (exp_q.size() == 0) chk("unexpected_event", 32'(got), 32'd0);
                else chk("event", 32'(got), 32'(exp_q.pop_front()));
                if (trap_ack) trap_req = 1'b0;
                if (rett_ack) rett_req = 1'b0;
            end
            @(posedge clk);
            #1;
            if (drop_s) sw_req = 1'b0;
            if (drop_a) alu_req = 1'b0;
            @(negedge clk);
        end
        chk("timeout_pending_reqs", {28'd0, trap_req, rett_req, sw_req, alu_req}, 32'd0);
        trap_req = 1'b0;
        rett_req = 1'b0;
        sw_req   = 1'b0;
        alu_req  = 1'b0;
        chk("events_left", exp_q.size(), 32'd0);
        chk("write_count", wr_cnt - wr0, n_wr);
        chk("psr", 32'(psr), 32'(m_psr));
        chk("depth", 32'(depth), m_stack.size());
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("unf_err", 32'(unf_err), 32'(m_unf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 4'b0101, 1'b1, 10'b10001_10101};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b01110, 4'b0011, 1'b0, 10'b01001_01110};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11111, 4'b1111, 1'b1, 10'b00000_00000};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 4'b1100, 1'b1, 10'b00000_00000};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10101, 4'b1111, 1'b1, 10'b00000_00000};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10101, 4'b0101, 1'b1, 10'b00000_00000};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 4'b1010, 1'b0, 10'b10001_01010};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 4'b0000, 1'b0, 10'b01001_11111};

        reset     = 1'b0;
        trap_req  = 1'b0;
        rett_req  = 1'b0;
        sw_req    = 1'b1;
        alu_req   = 1'b1;
        sw_data   = 5'b10101;
        alu_flags = 4'b1111;
        alu_disp  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", {22'd0, alu_gnt, sw_gnt, trap_ack, rett_ack, psr_rw, psr_wdata}, 32'd0);
        chk("reset_depth", 32'(depth), 32'd0);
        chk("reset_errs", {30'd0, ovf_err, unf_err}, 32'd0);
        sw_req  = 1'b0;
        alu_req = 1'b0;
        reset   = 1'b1;

        // Combinational IDLE arbitration; requests drop before each edge so no state moves.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset     = vecs[i].rst_n;
            trap_req  = vecs[i].trap;
            rett_req  = vecs[i].rett;
            sw_req    = vecs[i].sw;
            alu_req   = vecs[i].alu;
            sw_data   = vecs[i].sw_data;
            alu_flags = vecs[i].flags;
            alu_disp  = vecs[i].disp;
            #1;
            chk($sformatf("vec%0d", i),
                {22'd0, alu_gnt, sw_gnt, trap_ack, rett_ack, psr_rw, psr_wdata},
                {22'd0, vecs[i].exp});
            #1;
            trap_req = 1'b0;
            rett_req = 1'b0;
            sw_req   = 1'b0;
            alu_req  = 1'b0;
            reset    = 1'b1;
        end
        chk("table_no_writes", wr_cnt, 32'd0);

        serve(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'b0101, 1'b1);
        serve(1'b0, 1'b0, 1'b1, 1'b1, 5'b00110, 4'b1001, 1'b0);
        serve(1'b0, 1'b0, 1'b1, 1'b0, 5'b11010, 4'd0, 1'b0);
        serve(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        serve(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);

        for (int k = 0; k < 5; k++) begin
            serve(1'b0, 1'b0, 1'b1, 1'b0, 5'(5'd16 + 5'(k * 3 + 1)), 4'd0, 1'b0);
            serve(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        end
        chk("nested_depth_full", 32'(depth), 32'd4);
        chk("nested_ovf", 32'(ovf_err), 32'd1);
        for (int k = 0; k < 4; k++) begin
            serve(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        end
        serve(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        chk("underflow_flag", 32'(unf_err), 32'd1);

        // Reset landing in TRAP_SAVE with an ALU request waiting.
        serve(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
        @(negedge clk);
        trap_req  = 1'b1;
        alu_req   = 1'b1;
        alu_flags = 4'b0110;
        alu_disp  = 1'b0;
        #1;
        chk("t6_trap_beats_alu", 32'(alu_gnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        trap_req = 1'b0;
        #1;
        chk("t6_outputs_in_reset", {22'd0, alu_gnt, sw_gnt, trap_ack, rett_ack, psr_rw, psr_wdata}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_depth_cleared", 32'(depth), 32'd0);
        chk("t6_errs_cleared", {30'd0, ovf_err, unf_err}, 32'd0);
        chk("t6_alu_first_idle", {26'd0, alu_gnt, trap_ack, psr_rw, psr_wdata}, {26'd0, 1'b1, 1'b0, 1'b1, 5'b00110});
        @(posedge clk);
        #1;
        alu_req = 1'b0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_psr = 5'b00110;
        @(negedge clk);
        chk("t6_psr", 32'(psr), 32'(m_psr));

        for (int n = 0; n < 80; n++) begin
            bit t, r, s, a;
            t = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 1) == 0);
            if (!(t || r || s)) a = 1'b1;
            serve(t, r, s, a, 5'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
